// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams a program into the instruction memory from address 0 and zero-fills
// the remaining words. It then holds the CPU in run until a new load is requested.
module imem_boot_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   DepthLen = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StFill, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic              done_q;
    logic              err_q;

    logic len_bad;
    logic last_word;

    assign len_bad   = load_len > DepthLen;
    assign last_word = ({1'b0, addr_q} + (ADDR_W + 1)'(1)) == len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle, StRun: begin
                    if (load_start) begin
                        if (len_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= '0;
                            len_q   <= load_len;
                            state_q <= (load_len == '0) ? StFill : StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (load_start) err_q <= 1'b1;
                    if (in_valid) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (last_word) begin
                            // A full-depth program leaves nothing to zero-fill.
                            if (len_q == DepthLen) begin
                                state_q <= StRun;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StFill;
                            end
                        end
                    end
                end
                StFill: begin
                    if (load_start) err_q <= 1'b1;
                    addr_q <= addr_q + ADDR_W'(1);
                    if (addr_q == LastAddr) begin
                        state_q <= StRun;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        cpu_run   = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addr  = addr_q;
                mem_wdata = in_data;
                busy      = 1'b1;
            end
            StFill: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                busy     = 1'b1;
            end
            StRun:   cpu_run = 1'b1;
            default: ;
        endcase
    end

    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a vector table of loads plus hand sequences for
// rejected starts and asynchronous reset mid-load.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [6:0]  load_len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        cpu_run;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [64];
    int          n_load;
    int          n_fill;

    typedef struct {
        int len;
        bit gap;
        bit poke;
        int exp_cycles;
    } vec_t;

    vec_t vecs [6];

    imem_boot_loader #(.DEPTH(64), .ADDR_W(6), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_len  (load_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_run   (cpu_run),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model fed from the write port; also guards writes while the CPU runs.
    always @(negedge clk) begin
        if (rst) begin
            check("we_while_run", 32'(mem_we & cpu_run), 32'd0);
            if (mem_we) begin
                mem_model[mem_addr] = mem_wdata;
                if (in_ready) n_load++;
                else n_fill++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int v, input int i);
        return (32'(v + 1) << 24) | 32'(i + 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic run_load(input int v, input int len, input bit gap, input bit poke,
                            input int exp_cycles);
        int   cycles;
        int   idx;
        int   bad_addr;
        logic hs;
        for (int i = 0; i < 64; i++) mem_model[i] = 32'hDEAD_BEEF;
        n_load = 0;
        n_fill = 0;
        load_start = 1'b1;
        load_len   = 7'(len);
        tick;
        load_start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("run_low_after_start", 32'(cpu_run), 32'd0);
        cycles = 0;
        idx    = 0;
        while (!cpu_run && cycles < 200) begin
            in_valid = (idx < len) && (!gap || (cycles % 2 == 0));
            in_data  = word(v, idx);
            if (poke && cycles == 1) begin
                load_start = 1'b1;
                load_len   = 7'd5;
            end
            #1;
            if (in_ready) begin
                check("load_addr", 32'(mem_addr), 32'(idx));
                if (!in_valid) check("no_write_on_gap", 32'(mem_we), 32'd0);
            end
            hs = in_valid && in_ready;
            tick;
            cycles++;
            load_start = 1'b0;
            if (hs) idx++;
            if (poke && cycles == 2) check("err_in_load", 32'(err), 32'd1);
        end
        in_valid = 1'b0;
        check("cycles_to_run", 32'(cycles), 32'(exp_cycles));
        check("done_first_run", 32'(done), 32'd1);
        check("load_writes", 32'(n_load), 32'(len));
        check("fill_writes", 32'(n_fill), 32'(64 - len));
        bad_addr = -1;
        for (int i = 63; i >= 0; i--) begin
            if (mem_model[i] !== ((i < len) ? word(v, i) : 32'd0)) bad_addr = i;
        end
        check("mem_first_bad_addr", 32'(bad_addr), 32'hFFFF_FFFF);
        tick;
        check("done_pulse_end", 32'(done), 32'd0);
        check("run_stays", 32'(cpu_run), 32'd1);
    endtask

    initial begin
        vecs[0] = '{len: 3,  gap: 1'b0, poke: 1'b0, exp_cycles: 64};
        vecs[1] = '{len: 4,  gap: 1'b1, poke: 1'b0, exp_cycles: 67};
        vecs[2] = '{len: 64, gap: 1'b0, poke: 1'b0, exp_cycles: 64};
        vecs[3] = '{len: 0,  gap: 1'b0, poke: 1'b0, exp_cycles: 64};
        vecs[4] = '{len: 1,  gap: 1'b0, poke: 1'b0, exp_cycles: 64};
        vecs[5] = '{len: 3,  gap: 1'b0, poke: 1'b1, exp_cycles: 64};

        rst        = 1'b0;
        load_start = 1'b0;
        load_len   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        n_load     = 0;
        n_fill     = 0;
        #2;
        check_all_zero("reset");
        tick;
        tick;
        rst = 1'b1;
        tick;

        // Oversized length in IDLE is rejected without writes.
        load_start = 1'b1;
        load_len   = 7'd65;
        tick;
        load_start = 1'b0;
        check("idle_err_pulse", 32'(err), 32'd1);
        check("idle_err_busy", 32'(busy), 32'd0);
        check("idle_err_run", 32'(cpu_run), 32'd0);
        tick;
        check("idle_err_clear", 32'(err), 32'd0);
        check("idle_err_busy2", 32'(busy), 32'd0);
        check("idle_err_writes", 32'(n_load + n_fill), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_load(v, vecs[v].len, vecs[v].gap, vecs[v].poke, vecs[v].exp_cycles);
        end

        // Oversized length in RUN keeps the CPU running.
        load_start = 1'b1;
        load_len   = 7'd65;
        tick;
        load_start = 1'b0;
        check("run_err_pulse", 32'(err), 32'd1);
        check("run_err_run", 32'(cpu_run), 32'd1);
        tick;
        check("run_err_clear", 32'(err), 32'd0);
        check("run_err_run2", 32'(cpu_run), 32'd1);

        // Asynchronous reset after 10 words of a 20-word load.
        load_start = 1'b1;
        load_len   = 7'd20;
        tick;
        load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = word(9, i);
            tick;
        end
        check("mid_load_busy", 32'(busy), 32'd1);
        check("mid_load_addr", 32'(mem_addr), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        run_load(6, 2, 1'b0, 1'b0, 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
